// File: rtl/seq_adder_nbit_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states and
// operation-mode constants.
package seq_adder_nbit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic is_sub(input logic mode);
    return mode == MODE_SUB;
  endfunction

endpackage

// File: rtl/seq_adder_nbit_digit_adder.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its MSB so the
// caller can form the two's-complement overflow flag.
module digit_adder #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/seq_adder_nbit.sv
// Digit-serial WIDTH-bit adder/subtractor: one shared DIGIT-bit slice walks
// the operands LSB digit first, with a carry register between cycles.
module seq_adder_nbit
  import seq_adder_nbit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, cout_q, ovf_q, done_q;
  logic             load, step, last;

  logic [DIGIT-1:0] a_dig, b_dig, d_sum;
  logic             d_cout, d_cmsb;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (count_q == LAST) begin
          state_d = ST_IDLE;
          last    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_dig = a_q[int'(count_q) * DIGIT +: DIGIT];
  assign b_dig = b_q[int'(count_q) * DIGIT +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry_q),
    .sum  (d_sum),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  // Subtraction is A + ~B + 1: invert B once at load and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (load) begin
        a_q     <= num1;
        b_q     <= is_sub(mode) ? ~num2 : num2;
        carry_q <= (mode == MODE_ADD) ? cin : 1'b1;
        count_q <= '0;
      end
      if (step) begin
        sum_q[int'(count_q) * DIGIT +: DIGIT] <= d_sum;
        carry_q <= d_cout;
        count_q <= last ? '0 : count_q + CW'(1);
      end
      if (last) begin
        cout_q <= d_cout;
        ovf_q  <= d_cmsb ^ d_cout;
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
